ex_stage: RTL and testbench

Execute stage of the 16-bit MIPS-style pipeline, directly upstream of the memory stage. It combines the ID/EX operands in a single-cycle ALU or in an iterative 16-step multiply/divide unit. It registers the result, the zero flag and the pass-through control bits into the EX/MEM register, which drives the memory stage's inputs. A stall output holds the decode stage while a multi-cycle operation is in flight. A flush input squashes the instruction on a taken jump.

---
 rtl/ex_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU, iterative MUL/DIVU, EX/MEM register
// Multi-cycle ops stall decode for 16 cycles; flush and reset squash to a bubble.
module ex_stage #(
   parameter int WIDTH = 16,
   parameter int STEPS = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             flush,
   input  logic [3:0]       aluop,
   input  logic             alu_src,
   input  logic [WIDTH-1:0] regA,
   input  logic [WIDTH-1:0] regB,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] PC_ID,
   input  logic [1:0]       rd_ID,
   input  logic             Wr_ID,
   input  logic             Wm_ID,
   input  logic             Rm_ID,
   input  logic             Neq_ID,
   input  logic             J_ID,
   input  logic             JC_ID,
   output logic             stall,
   output logic [WIDTH-1:0] acOutValue,
   output logic [WIDTH-1:0] RegVal,
   output logic             zeroOut,
   output logic [WIDTH-1:0] PC,
   output logic [1:0]       rdex,
   output logic             Wr,
   output logic             Wm,
   output logic             Rm,
   output logic             Neq,
   output logic             J,
   output logic             JC
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LAST    = 4'(STEPS - 1);
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_DIVU = 4'd10;

   state_t           r_state, w_state_n;
   logic [3:0]       r_cnt, w_cnt_n;
   logic             w_is_multi, w_start, w_finish, w_load_alu, w_stall;
   logic [WIDTH-1:0] w_b, w_alu;
   logic             w_lt;
   logic [5:0]       w_ctl_in;

   logic             r_is_div;
   logic [WIDTH-1:0] r_acc, r_x, r_y;
   logic [WIDTH-1:0] r_l_regb, r_l_pc;
   logic [1:0]       r_l_rd;
   logic [5:0]       r_l_ctl;
   logic [WIDTH-1:0] w_acc_n, w_x_n, w_y_n, w_step_res;
   logic [WIDTH:0]   w_rs;
   logic             w_ge;

   logic [WIDTH-1:0] r_res, r_regval, r_pc;
   logic             r_zero;
   logic [1:0]       r_rd;
   logic [5:0]       r_ctl;

   assign w_b        = alu_src ? imm : regB;
   assign w_lt       = $signed(regA) < $signed(w_b);
   assign w_is_multi = (aluop == OP_MUL) || (aluop == OP_DIVU);
   assign w_ctl_in   = {Wr_ID, Wm_ID, Rm_ID, Neq_ID, J_ID, JC_ID};

   always_comb begin
      w_alu = '0;
      case (aluop)
         4'd0:    w_alu = regA + w_b;
         4'd1:    w_alu = regA - w_b;
         4'd2:    w_alu = regA & w_b;
         4'd3:    w_alu = regA | w_b;
         4'd4:    w_alu = regA ^ w_b;
         4'd5:    w_alu = ~(regA | w_b);
         4'd6:    w_alu = regA << w_b[3:0];
         4'd7:    w_alu = regA >> w_b[3:0];
         4'd8:    w_alu = {{(WIDTH-1){1'b0}}, w_lt};
         4'd11:   w_alu = w_b;
         default: w_alu = '0;
      endcase
   end

   // One iteration: MUL shift-add (acc += x when y[0]) or restoring DIVU
   // (acc = remainder, x = dividend shifting out / quotient shifting in).
   assign w_rs = {r_acc, r_x[WIDTH-1]};
   assign w_ge = w_rs >= {1'b0, r_y};

   always_comb begin
      w_acc_n = r_acc;
      w_x_n   = r_x;
      w_y_n   = r_y;
      if (r_is_div) begin
         w_acc_n = w_ge ? (w_rs[WIDTH-1:0] - r_y) : w_rs[WIDTH-1:0];
         w_x_n   = {r_x[WIDTH-2:0], w_ge};
      end else begin
         w_acc_n = r_acc + (r_y[0] ? r_x : '0);
         w_x_n   = r_x << 1;
         w_y_n   = r_y >> 1;
      end
   end

   assign w_step_res = r_is_div ? w_x_n : w_acc_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_stall    = 1'b0;
      w_start    = 1'b0;
      w_finish   = 1'b0;
      w_load_alu = 1'b0;
      if (flush) begin
         w_state_n = IDLE;
         w_cnt_n   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_is_multi) begin
                     w_state_n = BUSY;
                     w_cnt_n   = '0;
                     w_stall   = 1'b1;
                     w_start   = 1'b1;
                  end else begin
                     w_load_alu = 1'b1;
                  end
               end
            end
            BUSY: begin
               if (r_cnt == LAST) begin
                  w_state_n = IDLE;
                  w_cnt_n   = '0;
                  w_finish  = 1'b1;
               end else begin
                  w_cnt_n = r_cnt + 4'd1;
                  w_stall = 1'b1;
               end
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   assign stall = w_stall & ~reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_is_div <= 1'b0;
         r_acc    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_l_regb <= '0;
         r_l_pc   <= '0;
         r_l_rd   <= '0;
         r_l_ctl  <= '0;
      end else if (w_start) begin
         r_is_div <= (aluop == OP_DIVU);
         r_acc    <= '0;
         r_x      <= regA;
         r_y      <= w_b;
         r_l_regb <= regB;
         r_l_pc   <= PC_ID;
         r_l_rd   <= rd_ID;
         r_l_ctl  <= w_ctl_in;
      end else if (r_state == BUSY) begin
         r_acc <= w_acc_n;
         r_x   <= w_x_n;
         r_y   <= w_y_n;
      end
   end

   // Anything other than a completed instruction loads a bubble.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_res    <= '0;
         r_zero   <= 1'b0;
         r_regval <= '0;
         r_pc     <= '0;
         r_rd     <= '0;
         r_ctl    <= '0;
      end else if (w_load_alu) begin
         r_res    <= w_alu;
         r_zero   <= (w_alu == '0);
         r_regval <= regB;
         r_pc     <= PC_ID;
         r_rd     <= rd_ID;
         r_ctl    <= w_ctl_in;
      end else if (w_finish) begin
         r_res    <= w_step_res;
         r_zero   <= (w_step_res == '0);
         r_regval <= r_l_regb;
         r_pc     <= r_l_pc;
         r_rd     <= r_l_rd;
         r_ctl    <= r_l_ctl;
      end else begin
         r_res    <= '0;
         r_zero   <= 1'b0;
         r_regval <= '0;
         r_pc     <= '0;
         r_rd     <= '0;
         r_ctl    <= '0;
      end
   end

   assign acOutValue = r_res;
   assign zeroOut    = r_zero;
   assign RegVal     = r_regval;
   assign PC         = r_pc;
   assign rdex       = r_rd;
   assign {Wr, Wm, Rm, Neq, J, JC} = r_ctl;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
// Directed timing scenarios plus randomized ops against an arithmetic reference.
module tb_ex_stage;

   logic        clock = 1'b0;
   logic        reset, in_valid, flush, alu_src;
   logic [3:0]  aluop;
   logic [15:0] regA, regB, imm, PC_ID;
   logic [1:0]  rd_ID;
   logic [5:0]  ctl;
   logic        Wr_ID, Wm_ID, Rm_ID, Neq_ID, J_ID, JC_ID;
   logic        stall, zeroOut, Wr, Wm, Rm, Neq, J, JC;
   logic [15:0] acOutValue, RegVal, PC;
   logic [1:0]  rdex;
   logic [63:0] obs;

   int total = 0;
   int bad   = 0;

   assign {Wr_ID, Wm_ID, Rm_ID, Neq_ID, J_ID, JC_ID} = ctl;
   assign obs = {7'b0, acOutValue, RegVal, zeroOut, PC, rdex, Wr, Wm, Rm, Neq, J, JC};

   ex_stage #(.WIDTH(16), .STEPS(16)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .flush(flush),
      .aluop(aluop), .alu_src(alu_src), .regA(regA), .regB(regB), .imm(imm),
      .PC_ID(PC_ID), .rd_ID(rd_ID),
      .Wr_ID(Wr_ID), .Wm_ID(Wm_ID), .Rm_ID(Rm_ID), .Neq_ID(Neq_ID),
      .J_ID(J_ID), .JC_ID(JC_ID),
      .stall(stall), .acOutValue(acOutValue), .RegVal(RegVal), .zeroOut(zeroOut),
      .PC(PC), .rdex(rdex), .Wr(Wr), .Wm(Wm), .Rm(Rm), .Neq(Neq), .J(J), .JC(JC)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      logic [31:0] p;
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = 32'(a) * 32'(b);
      case (op)
         4'd0:    return 16'(a + b);
         4'd1:    return 16'(a - b);
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~(a | b);
         4'd6:    return a << b[3:0];
         4'd7:    return a >> b[3:0];
         4'd8:    return (sa < sb) ? 16'd1 : 16'd0;
         4'd9:    return p[15:0];
         4'd10:   return (b == 16'd0) ? 16'hFFFF : 16'(a / b);
         4'd11:   return b;
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic [63:0] exv(input logic [15:0] res, input logic [15:0] rb,
                                       input logic [15:0] pc, input logic [1:0] rd,
                                       input logic [5:0] c);
      return {7'b0, res, rb, (res == 16'd0), pc, rd, c};
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] im, input logic src, input logic [5:0] c,
                        input logic [1:0] rd, input logic [15:0] pc);
      in_valid = 1'b1; flush = 1'b0;
      aluop = op; regA = a; regB = b; imm = im; alu_src = src;
      ctl = c; rd_ID = rd; PC_ID = pc;
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] im, input logic src,
                         input logic [5:0] c, input logic [1:0] rd, input logic [15:0] pc);
      issue(op, a, b, im, src, c, rd, pc);
      #1 chk({tag, "_stall"}, 64'(stall), 64'd0);
      tick();
      chk(tag, obs, exv(ref_alu(op, a, src ? im : b), b, pc, rd, c));
   endtask

   task automatic multi(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] im, input logic src,
                        input logic [5:0] c, input logic [1:0] rd, input logic [15:0] pc);
      issue(op, a, b, im, src, c, rd, pc);
      for (int i = 0; i < 16; i++) begin
         #1 chk({tag, "_stall_hi"}, 64'(stall), 64'd1);
         tick();
         chk({tag, "_bubble"}, obs, 64'd0);
      end
      #1 chk({tag, "_stall_lo"}, 64'(stall), 64'd0);
      tick();
      chk(tag, obs, exv(ref_alu(op, a, src ? im : b), b, pc, rd, c));
   endtask

   task automatic idle(input string tag);
      in_valid = 1'b0; flush = 1'b0;
      #1 chk({tag, "_stall"}, 64'(stall), 64'd0);
      tick();
      chk(tag, obs, 64'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] a, b, im;
      logic        src;

      reset = 1'b1;
      issue(4'd0, 16'd3, 16'd4, 16'd0, 1'b0, 6'b100000, 2'd1, 16'h0040);
      for (int i = 0; i < 2; i++) begin
         #1 chk("reset_stall", 64'(stall), 64'd0);
         tick();
         chk("reset_out", obs, 64'd0);
      end
      reset = 1'b0;
      tick();
      chk("first_add", obs, exv(16'd7, 16'd4, 16'h0040, 2'd1, 6'b100000));

      single("add_wrap", 4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 6'b100000, 2'd1, 16'h0010);
      single("sub_zero", 4'd1, 16'd5, 16'h0, 16'd5, 1'b1, 6'b000100, 2'd2, 16'h0012);
      single("slt_neg", 4'd8, 16'hFFFF, 16'd1, 16'h0, 1'b0, 6'b100000, 2'd3, 16'h0014);
      single("srl_15", 4'd7, 16'h8000, 16'h0, 16'd15, 1'b1, 6'b100000, 2'd1, 16'h0016);
      single("reserved", 4'd13, 16'h1234, 16'h5678, 16'h0, 1'b0, 6'b010000, 2'd0, 16'h0018);

      multi("mul_dir", 4'd9, 16'h0123, 16'h0010, 16'h0, 1'b0, 6'b100000, 2'd2, 16'h0020);
      single("add_after_mul", 4'd0, 16'd10, 16'd20, 16'h0, 1'b0, 6'b100000, 2'd3, 16'h0022);
      multi("divu_100_7", 4'd10, 16'd100, 16'd7, 16'h0, 1'b0, 6'b100000, 2'd1, 16'h0024);
      multi("divu_by0", 4'd10, 16'd5, 16'd0, 16'h0, 1'b0, 6'b100000, 2'd1, 16'h0026);
      multi("mul_ffff", 4'd9, 16'hFFFF, 16'h0, 16'hFFFF, 1'b1, 6'b100001, 2'd2, 16'h0028);

      issue(4'd9, 16'h0123, 16'h0010, 16'h0, 1'b0, 6'b100000, 2'd2, 16'h0030);
      for (int i = 0; i < 8; i++) begin
         #1 chk("fl7_stall_hi", 64'(stall), 64'd1);
         tick();
      end
      flush = 1'b1;
      #1 chk("fl7_stall_drop", 64'(stall), 64'd0);
      tick();
      chk("fl7_bubble", obs, 64'd0);
      single("fl7_next_add", 4'd0, 16'd1, 16'd2, 16'h0, 1'b0, 6'b100000, 2'd1, 16'h0032);
      for (int i = 0; i < 12; i++) idle("fl7_no_result");

      issue(4'd9, 16'h0123, 16'h0010, 16'h0, 1'b0, 6'b100000, 2'd2, 16'h0040);
      flush = 1'b1;
      #1 chk("flissue_stall", 64'(stall), 64'd0);
      tick();
      chk("flissue_bubble", obs, 64'd0);
      for (int i = 0; i < 18; i++) idle("flissue_quiet");
      single("flissue_add", 4'd0, 16'd9, 16'd9, 16'h0, 1'b0, 6'b100000, 2'd3, 16'h0042);

      issue(4'd10, 16'd1000, 16'd3, 16'h0, 1'b0, 6'b100000, 2'd1, 16'h0050);
      tick(); tick(); tick();
      reset = 1'b1;
      #1 chk("rstbusy_stall", 64'(stall), 64'd0);
      tick();
      chk("rstbusy_out", obs, 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 18; i++) idle("rstbusy_quiet");

      for (int k = 0; k < 150; k++) begin
         op = 4'($urandom_range(0, 13));
         if (op >= 4'd9) op = op + 4'd2;
         a   = 16'($urandom);
         b   = (k % 7 == 0) ? a : 16'($urandom);
         im  = 16'($urandom);
         src = 1'($urandom);
         single("rnd_single", op, a, b, im, src, 6'($urandom), 2'($urandom), 16'($urandom));
      end

      for (int k = 0; k < 12; k++) begin
         op  = (k % 2 == 0) ? 4'd9 : 4'd10;
         a   = 16'($urandom);
         b   = (k % 6 == 3) ? 16'd0 : 16'($urandom_range(0, (k % 3 == 0) ? 255 : 65535));
         multi("rnd_multi", op, a, b, 16'($urandom), 1'b0, 6'($urandom), 2'($urandom),
               16'($urandom));
      end
      idle("final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
